fifo_reader: RTL
================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The module SHALL have parameter: width, default 8, data word width in bits.
REQ-002 The module SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 The module SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have port: enable  input  1  permits new reads from the FIFO.
REQ-005 The module SHALL have port: fifo_empty  input  1  FIFO empty flag.
REQ-006 The module SHALL have port: fifo_data  input  width  FIFO registered read data.
REQ-007 The module SHALL have port: fifo_rd_en  output  1  FIFO read request.
REQ-008 The module SHALL have port: m_ready  input  1  downstream ready.
REQ-009 The module SHALL have port: m_valid  output  1  downstream data valid.
REQ-010 The module SHALL have port: m_data  output  width  downstream data.
REQ-011 The module SHALL have port: busy  output  1  high when state is not IDLE.

Function
REQ-012 A FIFO read SHALL count as accepted at a clk edge where fifo_rd_en=1 and fifo_empty=0; fifo_data is valid in the cycle after that edge.
REQ-013 fifo_rd_en SHALL be combinational: state==ACTIVE && !fifo_empty && (occ + inflight) < 3, with no path from m_ready.
REQ-014 inflight SHALL be a 1-bit register set on an accepted read and cleared one cycle later; occ SHALL be the 0..3 occupancy of an internal 3-entry circular output buffer.
REQ-015 On the edge after an accepted read, fifo_data SHALL be written into the buffer at the write index, which then increments modulo 3.
REQ-016 m_valid SHALL equal (occ != 0); m_data SHALL be the buffer entry at the read index.
REQ-017 A transfer SHALL occur on an edge where m_valid && m_ready; the read index then increments modulo 3.
REQ-018 Simultaneous capture and transfer SHALL leave occ unchanged.
REQ-019 Latency from the accepted-read edge to m_valid=1 SHALL be exactly 1 cycle, so the first word appears 2 edges after the cycle in which fifo_rd_en was first asserted.
REQ-020 Throughput SHALL be one word per cycle sustained while fifo_empty=0 and m_ready=1.
REQ-021 Word order on m_data SHALL equal FIFO read order; no word is dropped or duplicated.
REQ-022 m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-023 The FSM SHALL use states IDLE, ACTIVE and DRAIN, with these transitions:
- IDLE->ACTIVE when enable=1.
- ACTIVE->DRAIN when enable=0.
- DRAIN->ACTIVE when enable=1.
- DRAIN->IDLE when inflight=0 && occ=0.
REQ-024 In DRAIN, fifo_rd_en SHALL be 0, and buffered and in-flight words SHALL still be delivered.
REQ-025 occ SHALL never exceed 3, and no capture SHALL be lost when occ=2 with inflight=1.

Reset
REQ-026 While rst=1 at an edge, the block SHALL clear state to IDLE, occ, inflight and both buffer indices to 0, and m_data to 0.
REQ-027 After reset, m_valid SHALL be 0, busy SHALL be 0 and fifo_rd_en SHALL be 0.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight words, and fifo_data arriving in the cycle after reset SHALL NOT be captured.
REQ-029 rst SHALL take priority over all other inputs.

Configuration
REQ-030 With macro FIFO_READER_CNT_EN defined, the module SHALL add output rd_count [15:0], reset to 0, which increments by 1 on every transfer and wraps from 16'hFFFF to 0.
REQ-031 Without FIFO_READER_CNT_EN, rd_count SHALL be absent and no counter logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-032 Single word: FIFO holds 8'hA5, enable=1, m_ready=1 -> m_valid=1 with m_data=8'hA5 exactly 2 edges after fifo_rd_en rises, then m_valid=0.
REQ-033 Streaming: FIFO holds 8 words 0x01..0x08, m_ready=1 -> 8 consecutive transfers 0x01..0x08 with no bubbles after the first.
REQ-034 Backpressure: m_ready=0 with FIFO non-empty -> occ reaches 3, fifo_rd_en=0, m_data stable; then m_ready=1 -> the 3 buffered words transfer in order.
REQ-035 Drain: drop enable while inflight=1 and occ=2 -> no further fifo_rd_en, 3 words delivered, then busy=0.
REQ-036 Reset mid-stream: assert rst with occ=2 -> m_valid=0 next cycle, and the word returned by the in-flight read is not delivered.
REQ-037 Counter (FIFO_READER_CNT_EN defined): 5 transfers -> rd_count=5; preload 16'hFFFF then 1 transfer -> rd_count=0.

Source files
------------

// File: rtl/fifo_reader.sv
// Pulls words from a registered-read FIFO into a 3-entry skid buffer and
// streams them downstream on a valid/ready interface. Define FIFO_READER_CNT_EN
// to add the 16-bit rd_count transfer counter.
module fifo_reader #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_data,
    output logic             fifo_rd_en,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [width-1:0] m_data,
`ifdef FIFO_READER_CNT_EN
    output logic [15:0]      rd_count,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       wr_idx_q, wr_idx_d;
    logic [1:0]       rd_idx_q, rd_idx_d;
    logic [width-1:0] buf_q [3];
    logic [width-1:0] buf_d [3];
    logic             capture, transfer;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Credit check counts the in-flight word so the buffer can never overflow.
    assign fifo_rd_en = (state_q == ACTIVE) && !fifo_empty &&
                        ((3'(occ_q) + 3'(inflight_q)) < 3'd3);
    assign capture    = inflight_q;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = buf_q[rd_idx_q];
    assign transfer   = m_valid && m_ready;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        inflight_d = fifo_rd_en && !fifo_empty;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        buf_d      = buf_q;

        unique case (state_q)
            IDLE:    if (enable) state_d = ACTIVE;
            ACTIVE:  if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)                             state_d = ACTIVE;
                else if (!inflight_q && occ_q == 2'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            buf_d[wr_idx_q] = fifo_data;
            wr_idx_d        = inc3(wr_idx_q);
        end
        if (transfer) rd_idx_d = inc3(rd_idx_q);

        if (capture && !transfer)      occ_d = occ_q + 2'd1;
        else if (!capture && transfer) occ_d = occ_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wr_idx_q   <= 2'd0;
            rd_idx_q   <= 2'd0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            buf_q      <= buf_d;
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [15:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        if (transfer) rd_count_d = rd_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_count_q <= 16'd0;
        else     rd_count_q <= rd_count_d;
    end

    assign rd_count = rd_count_q;
`endif

endmodule
